// File: rtl/uart_tx_fifo_reader_pkg.sv
// rtl/uart_tx_fifo_reader_pkg.sv - shared types and Gray-code helpers for the UART FIFO read side
//
// Purpose: common typedefs for the uart_clk read side of the processor-to-UART
// FIFO. It also holds the Gray/binary conversion functions used by that read
// side and by the write side.
// Ports: none (package).
//
// The helpers work on a 32-bit container. Callers zero-extend the pointer into
// the container and size-cast the result back, so one pair of functions serves
// every pointer width.
package uart_tx_fifo_reader_pkg;

  typedef logic bit_t;

  localparam int ADDR_BITS_DEFAULT = 4;
  localparam int PTR_W_DEFAULT     = ADDR_BITS_DEFAULT + 1;

  // Pointer with wrap bit for the default depth.
  typedef logic [PTR_W_DEFAULT-1:0] ptr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic logic [31:0] bin_to_gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above it.
  function automatic logic [31:0] gray_to_bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// rtl/gray_ptr_sync.sv - two-flop Gray pointer synchronizer with binary output
//
// Purpose: bring a Gray-coded FIFO pointer from a foreign clock domain into clk.
// It passes the pointer through two flops and then converts it to binary.
// Ports:
//   clk      in  1      destination clock
//   rst      in  1      asynchronous active-high reset
//   gray_in  in  WIDTH  Gray pointer from the other domain
//   bin_out  out WIDTH  synchronized pointer, binary
//
// Conversion happens after the second flop. The bus is only sampled while it
// is Gray-coded, so at most one bit can be in flight at any time.
module gray_ptr_sync
  import uart_tx_fifo_reader_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out
);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= gray_in;
      sync_q2 <= sync_q1;
    end
  end

  assign bin_out = WIDTH'(gray_to_bin(32'(sync_q2)));

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// rtl/uart_tx_fifo_reader.sv - async FIFO read side that pops words and sends 8N1 UART frames
//
// Purpose: read side of the processor-to-UART asynchronous FIFO, entirely in
// uart_clk. It derives the empty flag, pops one word at a time from the RAM and
// serializes each word LSB first with one start bit and one stop bit.
// Ports:
//   uart_clk    in  1            sole clock
//   reset       in  1            asynchronous active-high reset
//   w_ptr_gray  in  ADDR_BITS+1  write pointer (Gray, with wrap bit), foreign domain
//   rd_data     in  DATA_W       RAM read data, valid one cycle after r_add
//   r_add       out ADDR_BITS    RAM read address (low bits of read pointer)
//   r_ptr_gray  out ADDR_BITS+1  registered Gray read pointer for the write side
//   comp_empty  out 1            FIFO empty as seen in uart_clk
//   tx          out 1            UART line, idles high
//   tx_busy     out 1            high from LOAD through the end of STOP
module uart_tx_fifo_reader
  import uart_tx_fifo_reader_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_BITS    = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 uart_clk,
  input  logic                 reset,
  input  logic [ADDR_BITS:0]   w_ptr_gray,
  input  logic [DATA_W-1:0]    rd_data,
  output logic [ADDR_BITS-1:0] r_add,
  output logic [ADDR_BITS:0]   r_ptr_gray,
  output logic                 comp_empty,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int PTR_W  = ADDR_BITS + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  tx_state_t          state;
  tx_state_t          state_next;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  shift_reg;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_ptr_inc;
  logic [PTR_W-1:0]   w_ptr_sync;
  bit_t               baud_done;
  bit_t               load_en;

  gray_ptr_sync #(
    .WIDTH (PTR_W)
  ) u_w_ptr_sync (
    .clk     (uart_clk),
    .rst     (reset),
    .gray_in (w_ptr_gray),
    .bin_out (w_ptr_sync)
  );

  // Full-width compare. Equal low bits with different wrap bits means full.
  assign comp_empty = (r_ptr == w_ptr_sync);
  assign r_add      = r_ptr[ADDR_BITS-1:0];
  assign r_ptr_inc  = r_ptr + PTR_W'(1);
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign tx_busy    = (state != IDLE);

  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // tx is decoded from state, so an asynchronous reset returns the line high at once.
  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        if (!comp_empty) state_next = LOAD;
      end
      LOAD: begin
        load_en    = 1'b1;
        state_next = START;
      end
      START: begin
        tx = 1'b0;
        if (baud_done) state_next = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (baud_done && (bit_cnt == BIT_LAST)) state_next = STOP;
      end
      STOP: begin
        if (baud_done) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The read pointer advances in LOAD, when the word moves into the shift
  // register. The slot goes back to the writer while the frame is still on the line.
  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      r_ptr      <= '0;
      r_ptr_gray <= '0;
    end else begin
      if ((state_next != state) || baud_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end

      if (load_en) begin
        shift_reg  <= rd_data;
        bit_cnt    <= '0;
        r_ptr      <= r_ptr_inc;
        r_ptr_gray <= PTR_W'(bin_to_gray(32'(r_ptr_inc)));
      end else if ((state == DATA) && baud_done) begin
        shift_reg <= shift_reg >> 1;
        if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

endmodule
